// File: rtl/hazard_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sched_if
//  Description : Decode/execute side-band bundle between the core pipeline
//                (master) and the hazard scheduler (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_sched_if;
    logic [4:0] D_RS1;
    logic [4:0] D_RS2;
    logic [4:0] D_RD;
    logic       D_USE_RS1;
    logic       D_USE_RS2;
    logic       D_REGWRT;
    logic       D_MEMRD;
    logic       D_JUMP;
    logic       E_BRNEN;
    logic       STALL;
    logic       BUBBLE;
    logic       FLUSH;
    logic [1:0] FWD1_SEL;
    logic [1:0] FWD2_SEL;

    modport master (
        output D_RS1, D_RS2, D_RD, D_USE_RS1, D_USE_RS2,
               D_REGWRT, D_MEMRD, D_JUMP, E_BRNEN,
        input  STALL, BUBBLE, FLUSH, FWD1_SEL, FWD2_SEL
    );

    modport slave (
        input  D_RS1, D_RS2, D_RD, D_USE_RS1, D_USE_RS2,
               D_REGWRT, D_MEMRD, D_JUMP, E_BRNEN,
        output STALL, BUBBLE, FLUSH, FWD1_SEL, FWD2_SEL
    );
endinterface
`default_nettype wire

// File: rtl/hazard_sched.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sched
//  Description : RV32I hazard scheduler - E/M/W writer scoreboard, stall,
//                bubble and flush sequencing. Optional macro HAZARD_FWD_EN
//                enables operand forwarding selects.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_sched #(
    parameter int JWAIT_CYCLES = 4
) (
    input  wire logic     CLK,
    input  wire logic     RESET,
    hazard_sched_if.slave hz
);

    localparam int CNT_W = (JWAIT_CYCLES > 1) ? $clog2(JWAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(JWAIT_CYCLES - 1);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       load;
    } slot_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_JWAIT = 1'b1
    } state_e;

    slot_t            se_q, se_d, sm_q, sw_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       w_m1_e, w_m1_m, w_m1_w;
    logic       w_m2_e, w_m2_m, w_m2_w;
    logic       w_haz;
    logic [1:0] w_fwd1, w_fwd2;
    logic       w_stall, w_bubble, w_flush, w_issue;

    function automatic logic f_match(input logic use_x, input logic [4:0] rs,
                                     input slot_t s);
        return use_x && s.valid && (s.rd == rs) && (rs != 5'd0);
    endfunction

    assign w_m1_e = f_match(hz.D_USE_RS1, hz.D_RS1, se_q);
    assign w_m1_m = f_match(hz.D_USE_RS1, hz.D_RS1, sm_q);
    assign w_m1_w = f_match(hz.D_USE_RS1, hz.D_RS1, sw_q);
    assign w_m2_e = f_match(hz.D_USE_RS2, hz.D_RS2, se_q);
    assign w_m2_m = f_match(hz.D_USE_RS2, hz.D_RS2, sm_q);
    assign w_m2_w = f_match(hz.D_USE_RS2, hz.D_RS2, sw_q);

`ifdef HAZARD_FWD_EN
    // Youngest slot wins; only a load still in E cannot be forwarded yet.
    always_comb begin
        w_haz  = 1'b0;
        w_fwd1 = 2'd0;
        w_fwd2 = 2'd0;
        if (w_m1_e) begin
            if (se_q.load) w_haz  = 1'b1;
            else           w_fwd1 = 2'd1;
        end else if (w_m1_m) begin
            w_fwd1 = 2'd2;
        end
        if (w_m2_e) begin
            if (se_q.load) w_haz  = 1'b1;
            else           w_fwd2 = 2'd1;
        end else if (w_m2_m) begin
            w_fwd2 = 2'd2;
        end
    end
`else
    assign w_haz  = w_m1_e | w_m1_m | w_m1_w | w_m2_e | w_m2_m | w_m2_w;
    assign w_fwd1 = 2'd0;
    assign w_fwd2 = 2'd0;
`endif

    // Load flags of older slots and W matches are not consumed in every build.
    logic w_unused;
    assign w_unused = ^{se_q.load, sm_q.load, sw_q.load, w_m1_w, w_m2_w};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        w_flush  = 1'b0;
        w_issue  = 1'b0;

        // Jump countdown runs independently of a concurrent taken branch.
        if (state_q == ST_JWAIT) begin
            if (cnt_q == '0) state_d = ST_RUN;
            else             cnt_d   = cnt_q - CNT_W'(1);
        end

        if (hz.E_BRNEN) begin
            w_flush  = 1'b1;
            w_bubble = 1'b1;
        end else if (state_q == ST_JWAIT) begin
            w_flush  = 1'b1;
            w_bubble = 1'b1;
        end else if (w_haz) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
        end else begin
            w_issue = 1'b1;
            if (hz.D_JUMP) begin
                state_d = ST_JWAIT;
                cnt_d   = CNT_INIT;
            end
        end

        se_d = '0;
        if (w_issue && hz.D_REGWRT && (hz.D_RD != 5'd0)) begin
            se_d.valid = 1'b1;
            se_d.rd    = hz.D_RD;
            se_d.load  = hz.D_MEMRD;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            se_q    <= '0;
            sm_q    <= '0;
            sw_q    <= '0;
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            se_q    <= se_d;
            sm_q    <= se_q;
            sw_q    <= sm_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.STALL    = w_stall;
    assign hz.BUBBLE   = w_bubble;
    assign hz.FLUSH    = w_flush;
    assign hz.FWD1_SEL = w_fwd1;
    assign hz.FWD2_SEL = w_fwd2;

endmodule
`default_nettype wire

// File: tb/tb_hazard_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_sched
//  Description : Directed-vector scoreboard bench for hazard_sched; expected
//                {STALL,BUBBLE,FLUSH,FWD1_SEL,FWD2_SEL} queued per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_sched;

    localparam int JW = 4;

    // Stimulus flag bits: {use_rs1, use_rs2, regwrt, memrd, jump, brnen, reset}
    localparam logic [6:0] U1 = 7'b1000000;
    localparam logic [6:0] U2 = 7'b0100000;
    localparam logic [6:0] WR = 7'b0010000;
    localparam logic [6:0] LD = 7'b0001000;
    localparam logic [6:0] JM = 7'b0000100;
    localparam logic [6:0] BR = 7'b0000010;
    localparam logic [6:0] RS = 7'b0000001;
    localparam logic [6:0] NO = 7'b0000000;

    // Expected bits: {stall, bubble, flush, fwd1[1:0], fwd2[1:0]}
    localparam logic [6:0] X0  = 7'b0000000;
    localparam logic [6:0] XSB = 7'b1100000;
    localparam logic [6:0] XBF = 7'b0110000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_sched_if hz_if();

    hazard_sched #(.JWAIT_CYCLES(JW)) u_dut (
        .CLK   (clk),
        .RESET (rst),
        .hz    (hz_if)
    );

    logic [6:0] exp_q[$];
    int         id_q[$];
    int         n_cmp  = 0;
    int         n_err  = 0;
    int         vec_id = 0;
    logic [6:0] m_exp, m_act;
    int         m_id;

    function automatic logic [6:0] fw(input logic [1:0] a, input logic [1:0] b);
        return {3'b000, a, b};
    endfunction

    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [6:0] f,
                        input logic [6:0] exp);
        @(posedge clk);
        #1;
        hz_if.D_RS1     = rs1;
        hz_if.D_RS2     = rs2;
        hz_if.D_RD      = rd;
        hz_if.D_USE_RS1 = f[6];
        hz_if.D_USE_RS2 = f[5];
        hz_if.D_REGWRT  = f[4];
        hz_if.D_MEMRD   = f[3];
        hz_if.D_JUMP    = f[2];
        hz_if.E_BRNEN   = f[1];
        rst             = f[0];
        exp_q.push_back(exp);
        id_q.push_back(vec_id);
        vec_id++;
    endtask

    task automatic drain();
        repeat (3) step(5'd0, 5'd0, 5'd0, NO, X0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            m_id  = id_q.pop_front();
            m_act = {hz_if.STALL, hz_if.BUBBLE, hz_if.FLUSH, hz_if.FWD1_SEL, hz_if.FWD2_SEL};
            n_cmp++;
            if (m_act !== m_exp) begin
                n_err++;
                $display("FAIL vec%0d: stall/bubble/flush/fwd1/fwd2 got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                         m_id, m_act[6], m_act[5], m_act[4], m_act[3:2], m_act[1:0],
                         m_exp[6], m_exp[5], m_exp[4], m_exp[3:2], m_exp[1:0]);
            end
        end
    end

    initial begin
        rst             = 1'b1;
        hz_if.D_RS1     = 5'd0;
        hz_if.D_RS2     = 5'd0;
        hz_if.D_RD      = 5'd0;
        hz_if.D_USE_RS1 = 1'b0;
        hz_if.D_USE_RS2 = 1'b0;
        hz_if.D_REGWRT  = 1'b0;
        hz_if.D_MEMRD   = 1'b0;
        hz_if.D_JUMP    = 1'b0;
        hz_if.E_BRNEN   = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        step(5'd0, 5'd0, 5'd0, RS, X0);

        // RAW: addi x5,x0,1 ; add x6,x5,x5
        step(5'd0, 5'd0, 5'd5, U1 | WR, X0);
`ifdef HAZARD_FWD_EN
        step(5'd5, 5'd5, 5'd6, U1 | U2 | WR, fw(2'd1, 2'd1));
        step(5'd6, 5'd5, 5'd9, U1 | U2 | WR, fw(2'd1, 2'd2));
`else
        repeat (3) step(5'd5, 5'd5, 5'd6, U1 | U2 | WR, XSB);
        step(5'd5, 5'd5, 5'd6, U1 | U2 | WR, X0);
`endif
        drain();

`ifdef HAZARD_FWD_EN
        // Same rd in SE and SM: youngest wins
        step(5'd0, 5'd0, 5'd5, U1 | WR, X0);
        step(5'd5, 5'd0, 5'd5, U1 | U2 | WR, fw(2'd1, 2'd0));
        step(5'd5, 5'd0, 5'd10, U1 | U2 | WR, fw(2'd1, 2'd0));
        drain();
`endif

        // Load-use: lw x7,0(x0) ; add x8,x7,x0
        step(5'd0, 5'd0, 5'd7, U1 | WR | LD, X0);
`ifdef HAZARD_FWD_EN
        step(5'd7, 5'd0, 5'd8, U1 | U2 | WR, XSB);
        step(5'd7, 5'd0, 5'd8, U1 | U2 | WR, fw(2'd2, 2'd0));
        step(5'd7, 5'd0, 5'd11, U1 | U2 | WR, X0);
`else
        repeat (3) step(5'd7, 5'd0, 5'd8, U1 | U2 | WR, XSB);
        step(5'd7, 5'd0, 5'd8, U1 | U2 | WR, X0);
`endif
        drain();

        // x0 destination: addi x0,x0,5 ; add x1,x0,x0
        step(5'd0, 5'd0, 5'd0, U1 | WR, X0);
        step(5'd0, 5'd0, 5'd1, U1 | U2 | WR, X0);
        drain();

        // Jump window: JAL x1, squashed writer of x3 held in decode
        step(5'd0, 5'd0, 5'd1, WR | JM, X0);
        repeat (JW) step(5'd0, 5'd0, 5'd3, WR | JM, XBF);
        step(5'd3, 5'd1, 5'd4, U1 | U2 | WR, X0);
        drain();

        // Taken branch during a load-use stall
        step(5'd0, 5'd0, 5'd5, U1 | WR | LD, X0);
        step(5'd5, 5'd0, 5'd6, U1 | WR, XSB);
`ifdef HAZARD_FWD_EN
        step(5'd5, 5'd0, 5'd6, U1 | WR | BR, XBF | fw(2'd2, 2'd0));
`else
        step(5'd5, 5'd0, 5'd6, U1 | WR | BR, XBF);
`endif
        step(5'd6, 5'd0, 5'd7, U1 | WR, X0);
        drain();

        // Reset while in JWAIT with SE valid
        step(5'd0, 5'd0, 5'd1, WR | JM, X0);
        step(5'd0, 5'd0, 5'd0, RS, XBF);
        step(5'd1, 5'd0, 5'd2, U1 | WR, X0);
        drain();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
